// File: rtl/gnss_te_pkg.sv
// rtl/gnss_te_pkg.sv - register map and event type codes shared by the TE event FIFO
package gnss_te_pkg;

  localparam logic [5:0] TE_FIFO_CTRL      = 6'h00;
  localparam logic [5:0] TE_FIFO_STATUS    = 6'h01;
  localparam logic [5:0] TE_FIFO_DATA      = 6'h02;
  localparam logic [5:0] TE_FIFO_WATERMARK = 6'h03;

  typedef enum logic [1:0] {
    TE_EV_NONE = 2'b00,
    TE_EV_PPS  = 2'b01,
    TE_EV_MEAS = 2'b10,
    TE_EV_BOTH = 2'b11
  } te_ev_type_e;

  function automatic te_ev_type_e te_ev_type(input logic pps, input logic meas);
    return te_ev_type_e'({meas, pps});
  endfunction

endpackage

// File: rtl/te_sync_fifo.sv
// rtl/te_sync_fifo.sv - DEPTH x 32 synchronous FIFO with flush, count and full/empty
module te_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic [AW:0]   count,
  output logic [AW:0]   count_nxt,
  output logic          full,
  output logic          empty
);

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign count_nxt = count_d;
  assign rdata     = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push  = push & (~full | pop) & ~flush;
    do_pop   = pop & ~empty & ~flush;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/te_event_fifo.sv
// rtl/te_event_fifo.sv - timestamps PPS and TE measurement events into a host-drained FIFO
// TE_FIFO_WATERMARK_IRQ_EN adds a WATERMARK register that sets the interrupt threshold.
module te_event_fifo
  import gnss_te_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 30
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                host_cs,
  input  logic                host_rd,
  input  logic                host_wr,
  input  logic [5:0]          host_addr,
  input  logic [31:0]         host_d4wt,
  output logic [31:0]         host_d4rd,
  input  logic                pps_event,
  input  logic                meas_event,
  input  logic [TS_WIDTH-1:0] te_count,
  output logic                fifo_irq
);

  localparam int AW = $clog2(DEPTH);

  logic              pps_s1_q, pps_s1_d, pps_s2_q, pps_s2_d, pps_dly_q, pps_dly_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic              ovf_q, ovf_d;
  logic              irq_q, irq_d;
  logic              pps_hit, meas_hit, pps_take, meas_take;
  logic              wr_en, rd_en, flush, push, pop;
  logic [31:0]       wdata, rdata;
  logic [AW:0]       fifo_count, fifo_count_nxt;
  logic              fifo_full, fifo_empty;
  logic [8:0]        count9, count9_nxt;
  te_ev_type_e       ev_type;
  logic              unused_wdata;
`ifdef TE_FIFO_WATERMARK_IRQ_EN
  logic [8:0]        wm_q, wm_d, wm_eff;
`endif

  assign count9       = 9'(fifo_count);
  assign count9_nxt   = 9'(fifo_count_nxt);
  assign fifo_irq     = irq_q;
  assign unused_wdata = ^host_d4wt[30:4];

  always_comb begin
    // Synchroniser keeps running while disabled so re-enable never sees a stale edge.
    pps_s1_d  = pps_event;
    pps_s2_d  = pps_s1_q;
    pps_dly_d = pps_s2_q;
    pps_hit   = pps_s2_q & ~pps_dly_q;
    meas_hit  = meas_event;

    wr_en     = host_cs & host_wr;
    rd_en     = host_cs & host_rd;
    flush     = wr_en & (host_addr == TE_FIFO_CTRL) & host_d4wt[31];
    pop       = rd_en & (host_addr == TE_FIFO_DATA);
    pps_take  = ctrl_q[0] & ctrl_q[1] & pps_hit;
    meas_take = ctrl_q[0] & ctrl_q[2] & meas_hit;
    push      = pps_take | meas_take;
    ev_type   = te_ev_type(pps_take, meas_take);
    wdata     = {ev_type, te_count};

    ctrl_d = ctrl_q;
    if (wr_en && host_addr == TE_FIFO_CTRL) ctrl_d = host_d4wt[3:0];

    ovf_d = ovf_q;
    if (wr_en && host_addr == TE_FIFO_STATUS && host_d4wt[11]) ovf_d = 1'b0;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
    if (flush) ovf_d = 1'b0;

`ifdef TE_FIFO_WATERMARK_IRQ_EN
    wm_d = wm_q;
    if (wr_en && host_addr == TE_FIFO_WATERMARK) wm_d = host_d4wt[8:0];
    wm_eff = (wm_d == 9'd0) ? 9'd1 : wm_d;
    irq_d  = ctrl_d[3] & ((count9_nxt >= wm_eff) | ovf_d);
`else
    irq_d  = ctrl_d[3] & ((count9_nxt != 9'd0) | ovf_d);
`endif
  end

  always_comb begin
    host_d4rd = '0;
    case (host_addr)
      TE_FIFO_CTRL:      host_d4rd = {28'd0, ctrl_q};
      TE_FIFO_STATUS:    host_d4rd = {20'd0, ovf_q, fifo_full, fifo_empty, count9};
      TE_FIFO_DATA:      host_d4rd = rdata;
`ifdef TE_FIFO_WATERMARK_IRQ_EN
      TE_FIFO_WATERMARK: host_d4rd = {23'd0, wm_q};
`endif
      default:           host_d4rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pps_s1_q  <= 1'b0;
      pps_s2_q  <= 1'b0;
      pps_dly_q <= 1'b0;
      ctrl_q    <= '0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
`ifdef TE_FIFO_WATERMARK_IRQ_EN
      wm_q      <= 9'd1;
`endif
    end else begin
      pps_s1_q  <= pps_s1_d;
      pps_s2_q  <= pps_s2_d;
      pps_dly_q <= pps_dly_d;
      ctrl_q    <= ctrl_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
`ifdef TE_FIFO_WATERMARK_IRQ_EN
      wm_q      <= wm_d;
`endif
    end
  end

  te_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .wdata     (wdata),
    .rdata     (rdata),
    .count     (fifo_count),
    .count_nxt (fifo_count_nxt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
